sccb_cfg_ctrl: RTL and testbench



---
 rtl/sccb_cfg_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_sccb_cfg_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_cfg_ctrl.sv
// OV7670 SCCB configuration sequencer. Walks an external register table and issues one
// 3-phase SCCB write (device address, register, value) per entry, honouring delay and
// end markers. Bus timing is built from 4-quarter units of QUARTER clk cycles each.
module sccb_cfg_ctrl #(
  parameter int unsigned QUARTER      = 250,
  parameter logic [7:0]  DEV_ADDR     = 8'h42,
  parameter int unsigned DELAY_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  input  logic        siod_in,
  output logic        sioc,
  output logic        siod_out,
  output logic        siod_oe,
  output logic        busy,
  output logic        done,
  output logic        nack
);

  localparam int unsigned QW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
  localparam int unsigned DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [QW-1:0] QLast = QW'(QUARTER - 1);
  localparam logic [DW-1:0] DLast = DW'((DELAY_CYCLES > 0) ? DELAY_CYCLES - 1 : 0);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StFetch = 3'd1;
  localparam logic [2:0] StStart = 3'd2;
  localparam logic [2:0] StBit   = 3'd3;
  localparam logic [2:0] StStop  = 3'd4;
  localparam logic [2:0] StGap   = 3'd5;
  localparam logic [2:0] StWait  = 3'd6;
  localparam logic [2:0] StDone  = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    phase_q, phase_d;
  logic [4:0]    bit_q, bit_d;
  logic          fetch_q, fetch_d;
  logic [DW-1:0] dly_q, dly_d;
  logic [7:0]    reg_q, reg_d;
  logic [7:0]    val_q, val_d;
  logic [7:0]    rom_addr_q, rom_addr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          nack_q, nack_d;

  logic          quarter_done;
  logic          unit_done;
  logic          ack_slot;
  logic [26:0]   frame;
  logic          tx_bit;

  assign quarter_done = (qcnt_q == QLast);
  assign unit_done    = quarter_done && (phase_q == 2'd3);
  // Ninth bit of each byte is the don't-care/ACK slot.
  assign ack_slot     = (bit_q == 5'd8) || (bit_q == 5'd17) || (bit_q == 5'd26);
  assign frame        = {DEV_ADDR, 1'b1, reg_q, 1'b1, val_q, 1'b1};
  assign tx_bit       = frame[5'd26 - bit_q];

  // Next-state logic: sequencing, table decode, counters and status flags.
  always_comb begin
    state_d    = state_q;
    qcnt_d     = qcnt_q;
    phase_d    = phase_q;
    bit_d      = bit_q;
    fetch_d    = fetch_q;
    dly_d      = dly_q;
    reg_d      = reg_q;
    val_d      = val_q;
    rom_addr_d = rom_addr_q;
    busy_d     = busy_q;
    done_d     = done_q;
    nack_d     = nack_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StFetch;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          nack_d     = 1'b0;
          rom_addr_d = 8'd0;
          fetch_d    = 1'b0;
        end
      end
      StFetch: begin
        // First cycle lets the synchronous ROM respond; decode on the second.
        if (!fetch_q) begin
          fetch_d = 1'b1;
        end else begin
          fetch_d = 1'b0;
          reg_d   = rom_data[15:8];
          val_d   = rom_data[7:0];
          if (rom_data == 16'hFFFF) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (rom_data[15:8] == 8'hFF) begin
            state_d = StWait;
            dly_d   = '0;
          end else begin
            state_d = StStart;
          end
        end
      end
      StStart: begin
        if (unit_done) begin
          state_d = StBit;
          bit_d   = 5'd0;
        end
      end
      StBit: begin
        // Sample the ACK slot at the midpoint of SIOC high.
        if (ack_slot && quarter_done && (phase_q == 2'd2) && siod_in) begin
          nack_d = 1'b1;
        end
        if (unit_done) begin
          if (bit_q == 5'd26) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + 5'd1;
          end
        end
      end
      StStop: begin
        if (unit_done) begin
          state_d = StGap;
        end
      end
      StGap, StWait: begin
        if ((state_q == StGap) ? unit_done : (dly_q == DLast)) begin
          if (rom_addr_q == 8'hFF) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d    = StFetch;
            fetch_d    = 1'b0;
            rom_addr_d = rom_addr_q + 8'd1;
          end
        end else if (state_q == StWait) begin
          dly_d = dly_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Quarter timebase restarts on every state change.
    if (state_d != state_q) begin
      qcnt_d  = '0;
      phase_d = 2'd0;
    end else if (quarter_done) begin
      qcnt_d  = '0;
      phase_d = phase_q + 2'd1;
    end else begin
      qcnt_d  = qcnt_q + 1'b1;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      qcnt_q     <= '0;
      phase_q    <= 2'd0;
      bit_q      <= 5'd0;
      fetch_q    <= 1'b0;
      dly_q      <= '0;
      reg_q      <= 8'd0;
      val_q      <= 8'd0;
      rom_addr_q <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      qcnt_q     <= qcnt_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      fetch_q    <= fetch_d;
      dly_q      <= dly_d;
      reg_q      <= reg_d;
      val_q      <= val_d;
      rom_addr_q <= rom_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      nack_q     <= nack_d;
    end
  end

  // Bus pin decode from the registered state; idle bus is released high.
  always_comb begin
    sioc     = 1'b1;
    siod_out = 1'b1;
    siod_oe  = 1'b1;
    case (state_q)
      StStart: begin
        // Q0 idle, Q1 SIOD falls with SIOC high, Q2/Q3 SIOC low.
        sioc     = ~phase_q[1];
        siod_out = (phase_q == 2'd0);
      end
      StBit: begin
        sioc     = phase_q[1];
        siod_out = ack_slot | tx_bit;
        siod_oe  = ~ack_slot;
      end
      StStop: begin
        // Q0 both low, Q1 SIOC rises, Q2/Q3 SIOD rises.
        sioc     = (phase_q != 2'd0);
        siod_out = phase_q[1];
      end
      default: ;
    endcase
  end

  assign rom_addr = rom_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign nack     = nack_q;

endmodule

// File: tb/tb_sccb_cfg_ctrl.sv
// Directed bench for sccb_cfg_ctrl: synchronous ROM model, SCCB bus monitor, table of runs
// plus hand sequences for ACK timing, busy lockout/rerun and asynchronous reset.
module tb_sccb_cfg_ctrl;

  localparam int unsigned Q  = 4;
  localparam int unsigned DC = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        siod_in;
  logic        sioc, siod_out, siod_oe, busy, done, nack;
  logic        ack_drive;

  logic [15:0] rom [256];

  sccb_cfg_ctrl #(
    .QUARTER     (Q),
    .DEV_ADDR    (8'h42),
    .DELAY_CYCLES(DC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .siod_in (siod_in),
    .sioc    (sioc),
    .siod_out(siod_out),
    .siod_oe (siod_oe),
    .busy    (busy),
    .done    (done),
    .nack    (nack)
  );

  always #5 clk = ~clk;

  // 1-cycle synchronous ROM
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Released line reads back whatever the camera drives in the ACK slot
  assign siod_in = siod_oe ? siod_out : ack_drive;

  // ---------------- bus monitor (negedge samples) ----------------
  int          cyc = 0, busy_cyc = 0, oe_low = 0, sioc_low = 0, siod_low = 0;
  int          malformed = 0, bitcnt = 0, last_stop = 0, last_gap = 0;
  logic        in_frame = 1'b0, pend = 1'b0, pend_bit = 1'b0;
  logic        prev_sioc = 1'b1, prev_sda = 1'b1, sda;
  logic [26:0] shreg = '0;
  logic [26:0] frames[$];

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      in_frame  = 1'b0;
      pend      = 1'b0;
      prev_sioc = 1'b1;
      prev_sda  = 1'b1;
    end else begin
      sda = siod_in;
      if (busy) busy_cyc++;
      if (!siod_oe) oe_low++;
      if (!sioc) sioc_low++;
      if (!siod_out) siod_low++;
      if (prev_sioc && sioc && prev_sda && !sda) begin
        in_frame = 1'b1;
        bitcnt   = 0;
        pend     = 1'b0;
        last_gap = cyc - last_stop;
      end else if (prev_sioc && sioc && !prev_sda && sda) begin
        if (in_frame && bitcnt == 27) frames.push_back(shreg);
        else malformed++;
        in_frame  = 1'b0;
        pend      = 1'b0;
        last_stop = cyc;
      end else if (!prev_sioc && sioc) begin
        pend     = 1'b1;
        pend_bit = sda;
      end else if (prev_sioc && !sioc && pend) begin
        // Bits commit on SIOC fall so the stop's clock pulse is not counted
        pend = 1'b0;
        if (in_frame) begin
          shreg = {shreg[25:0], pend_bit};
          bitcnt++;
        end else begin
          malformed++;
        end
      end
      prev_sioc = sioc;
      prev_sda  = sda;
    end
  end

  // ---------------- checking helpers ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_rom(input logic [63:0] ents);
    for (int j = 0; j < 256; j++) rom[j] = 16'hFFFF;
    for (int j = 0; j < 4; j++) rom[j] = ents[63-16*j -: 16];
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: done=%b after %0d cycles, expected 1", done, n);
    end
  endtask

  task automatic chk_frame(input string nm, input int idx, input logic [7:0] r,
                           input logic [7:0] v);
    logic [26:0] f;
    f = frames[idx];
    chk({nm, "_dev"}, {24'd0, f[26:19]}, 32'h42);
    chk({nm, "_reg"}, {24'd0, f[17:10]}, {24'd0, r});
    chk({nm, "_val"}, {24'd0, f[8:1]}, {24'd0, v});
  endtask

  typedef struct {
    logic [63:0] ents;
    logic        ack;
    int          n_writes;
    logic [31:0] wr;
    int          exp_busy;
    logic        exp_nack;
    logic [7:0]  exp_addr;
    int          min_gap;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int b0, o0, s0, d0, f0, m0, n;

    vecs[0] = '{64'h1280_FFFF_FFFF_FFFF, 1'b0, 1, 32'h1280_0000, 484, 1'b0, 8'd1, 0};
    vecs[1] = '{64'h1280_FF00_1114_FFFF, 1'b0, 2, 32'h1280_1114, 1068, 1'b0, 8'd3, 116};
    vecs[2] = '{64'h1280_FFFF_FFFF_FFFF, 1'b1, 1, 32'h1280_0000, 484, 1'b1, 8'd1, 0};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 32'h0, 2, 1'b0, 8'd0, 0};
    vecs[4] = '{64'h3A04_40D0_FFFF_FFFF, 1'b0, 2, 32'h3A04_40D0, 966, 1'b0, 8'd2, 30};

    rst       = 1'b1;
    start     = 1'b0;
    ack_drive = 1'b0;
    load_rom(64'hFFFF_FFFF_FFFF_FFFF);
    repeat (3) tick();
    chk("rst_sioc", {31'd0, sioc}, 32'd1);
    chk("rst_siod_out", {31'd0, siod_out}, 32'd1);
    chk("rst_siod_oe", {31'd0, siod_oe}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_nack", {31'd0, nack}, 32'd0);
    chk("rst_rom_addr", {24'd0, rom_addr}, 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // ---------------- table-driven runs ----------------
    for (int i = 0; i < 5; i++) begin
      load_rom(vecs[i].ents);
      ack_drive = vecs[i].ack;
      b0 = busy_cyc; o0 = oe_low; s0 = sioc_low; d0 = siod_low;
      f0 = frames.size(); m0 = malformed;
      pulse_start();
      chk($sformatf("v%0d_busy_rise", i), {31'd0, busy}, 32'd1);
      wait_done(5000);
      tick();
      chk($sformatf("v%0d_busy_len", i), busy_cyc - b0, vecs[i].exp_busy);
      chk($sformatf("v%0d_done", i), {31'd0, done}, 32'd1);
      chk($sformatf("v%0d_nack", i), {31'd0, nack}, {31'd0, vecs[i].exp_nack});
      chk($sformatf("v%0d_rom_addr", i), {24'd0, rom_addr}, {24'd0, vecs[i].exp_addr});
      chk($sformatf("v%0d_frames", i), frames.size() - f0, vecs[i].n_writes);
      chk($sformatf("v%0d_malformed", i), malformed - m0, 0);
      chk($sformatf("v%0d_oe_low", i), oe_low - o0, 48 * vecs[i].n_writes);
      chk($sformatf("v%0d_sioc_low", i), sioc_low - s0, 228 * vecs[i].n_writes);
      if (vecs[i].n_writes == 0) chk($sformatf("v%0d_siod_low", i), siod_low - d0, 0);
      if (frames.size() - f0 == vecs[i].n_writes) begin
        for (int k = 0; k < vecs[i].n_writes; k++)
          chk_frame($sformatf("v%0d_w%0d", i, k), f0 + k, vecs[i].wr[31-16*k -: 8],
                    vecs[i].wr[23-16*k -: 8]);
      end
      if (vecs[i].min_gap > 0) begin
        checks++;
        if (last_gap < vecs[i].min_gap) begin
          errors++;
          $display("FAIL v%0d_gap: got %0d cycles, expected >= %0d", i, last_gap,
                   vecs[i].min_gap);
        end
      end
      ack_drive = 1'b0;
    end

    // ---------------- nack rises right after the first ACK slot ----------------
    load_rom(64'h1280_FFFF_FFFF_FFFF);
    ack_drive = 1'b1;
    pulse_start();
    n = 0;
    while (!(in_frame && bitcnt >= 8) && n < 1000) begin
      tick();
      n++;
    end
    chk("ack_before_slot", {31'd0, nack}, 32'd0);
    repeat (16) tick();
    chk("ack_after_slot", {31'd0, nack}, 32'd1);
    wait_done(5000);
    ack_drive = 1'b0;
    repeat (2) tick();

    // ---------------- busy lockout, then rerun ----------------
    b0 = busy_cyc; f0 = frames.size();
    pulse_start();
    repeat (100) tick();
    pulse_start();
    chk("lock_rom_addr", {24'd0, rom_addr}, 32'd0);
    chk("lock_busy", {31'd0, busy}, 32'd1);
    wait_done(5000);
    tick();
    chk("lock_busy_len", busy_cyc - b0, 484);
    chk("lock_frames", frames.size() - f0, 1);
    pulse_start();
    chk("rerun_done_clr", {31'd0, done}, 32'd0);
    chk("rerun_rom_addr", {24'd0, rom_addr}, 32'd0);
    wait_done(5000);
    tick();
    chk("rerun_end_addr", {24'd0, rom_addr}, 32'd1);
    chk("rerun_frames", frames.size() - f0, 2);
    if (frames.size() - f0 == 2) chk_frame("rerun_w0", f0 + 1, 8'h12, 8'h80);

    // ---------------- asynchronous reset mid-run ----------------
    load_rom(64'h3A04_40D0_FFFF_FFFF);
    ack_drive = 1'b1;
    pulse_start();
    repeat (600) tick();
    chk("pre_rst_addr", {24'd0, rom_addr}, 32'd1);
    chk("pre_rst_nack", {31'd0, nack}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_sioc", {31'd0, sioc}, 32'd1);
    chk("arst_siod_out", {31'd0, siod_out}, 32'd1);
    chk("arst_siod_oe", {31'd0, siod_oe}, 32'd1);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_nack", {31'd0, nack}, 32'd0);
    chk("arst_rom_addr", {24'd0, rom_addr}, 32'd0);
    ack_drive = 1'b0;
    tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_sioc", {31'd0, sioc}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
